// File: rtl/microwave_cook_timer_if.sv
// Front-panel bus of the microwave cook timer: keypad/command pulses and door level
// in, BCD display digits and magnetron/done indicators out.
interface microwave_cook_timer_if;
   logic       tick_1hz;
   logic       key_valid;
   logic [3:0] key_code;
   logic       start;
   logic       stop;
   logic       door_closed;
   logic [3:0] min_ones;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic       magnetron_on;
   logic       done;

   modport master (
      output tick_1hz, key_valid, key_code, start, stop, door_closed,
      input  min_ones, sec_tens, sec_ones, magnetron_on, done
   );

   modport slave (
      input  tick_1hz, key_valid, key_code, start, stop, door_closed,
      output min_ones, sec_tens, sec_ones, magnetron_on, done
   );
endinterface

// File: rtl/microwave_cook_timer.sv
// BCD M:SS cook timer: keypad entry in IDLE, 1 Hz countdown while cooking,
// pause/resume/cancel, and registered magnetron/done outputs.
module microwave_cook_timer (
   input logic                 clk,
   input logic                 rst_n,
   microwave_cook_timer_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StCooking, StPaused, StDone} state_e;

   state_e     state_q, state_d;
   logic [3:0] min_q, min_d;
   logic [3:0] tens_q, tens_d;
   logic [3:0] ones_q, ones_d;
   logic       mag_q, mag_d;
   logic       done_q, done_d;

   logic time_zero;
   logic last_sec;
   logic key_ok;

   assign time_zero = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);
   assign last_sec  = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd1);
   // Shifting a digit above 5 into the tens-of-seconds place would be an illegal time.
   assign key_ok    = bus.key_valid && (bus.key_code <= 4'd9) && (ones_q <= 4'd5);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         min_q   <= 4'd0;
         tens_q  <= 4'd0;
         ones_q  <= 4'd0;
         mag_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         min_q   <= min_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
         mag_q   <= mag_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      min_d   = min_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      unique case (state_q)
         StIdle: begin
            if (bus.stop) begin
               min_d  = 4'd0;
               tens_d = 4'd0;
               ones_d = 4'd0;
            end else if (bus.start && bus.door_closed && !time_zero) begin
               state_d = StCooking;
            end else if (key_ok) begin
               min_d  = tens_q;
               tens_d = ones_q;
               ones_d = bus.key_code;
            end
         end
         StCooking: begin
            if (bus.stop || !bus.door_closed) begin
               state_d = StPaused;
            end else if (bus.tick_1hz) begin
               if (ones_q != 4'd0) begin
                  ones_d = ones_q - 4'd1;
               end else begin
                  ones_d = 4'd9;
                  if (tens_q != 4'd0) begin
                     tens_d = tens_q - 4'd1;
                  end else begin
                     tens_d = 4'd5;
                     min_d  = min_q - 4'd1;
                  end
               end
               if (last_sec) state_d = StDone;
            end
         end
         StPaused: begin
            if (bus.stop) begin
               state_d = StIdle;
               min_d   = 4'd0;
               tens_d  = 4'd0;
               ones_d  = 4'd0;
            end else if (bus.start && bus.door_closed) begin
               state_d = StCooking;
            end
         end
         StDone: begin
            if (bus.key_valid || bus.start || bus.stop || !bus.door_closed) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Indicators are decoded from the next state so they change on the same edge as it.
   always_comb begin
      mag_d  = (state_d == StCooking);
      done_d = (state_d == StDone);
   end

   assign bus.min_ones     = min_q;
   assign bus.sec_tens     = tens_q;
   assign bus.sec_ones     = ones_q;
   assign bus.magnetron_on = mag_q;
   assign bus.done         = done_q;

endmodule

// File: tb/tb_microwave_cook_timer.sv
// Bench for microwave_cook_timer: directed panel scenarios plus random pulses, checked
// against a model that keeps the cook time as a plain count of seconds.
module tb_microwave_cook_timer;

   logic clk = 1'b0;
   logic rst_n;
   logic door;

   always #5 clk = ~clk;

   microwave_cook_timer_if bus ();

   microwave_cook_timer dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   localparam int MIdle    = 0;
   localparam int MCooking = 1;
   localparam int MPaused  = 2;
   localparam int MDone    = 3;

   int n_checks = 0;
   int n_fails  = 0;
   int m_mode;
   int m_t;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fails++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".min_ones"}, int'(bus.min_ones), m_t / 60);
      check({tag, ".sec_tens"}, int'(bus.sec_tens), (m_t % 60) / 10);
      check({tag, ".sec_ones"}, int'(bus.sec_ones), m_t % 10);
      check({tag, ".magnetron_on"}, int'(bus.magnetron_on), (m_mode == MCooking) ? 1 : 0);
      check({tag, ".done"}, int'(bus.done), (m_mode == MDone) ? 1 : 0);
   endtask

   task automatic model_step(input logic tk, input logic kv, input int kc,
                             input logic st, input logic sp, input logic dc);
      case (m_mode)
         MIdle: begin
            if (sp) m_t = 0;
            else if (st && dc && m_t != 0) m_mode = MCooking;
            else if (kv && kc <= 9 && (m_t % 10) <= 5)
               m_t = ((m_t % 60) / 10) * 60 + (m_t % 10) * 10 + kc;
         end
         MCooking: begin
            if (sp || !dc) m_mode = MPaused;
            else if (tk) begin
               m_t = m_t - 1;
               if (m_t == 0) m_mode = MDone;
            end
         end
         MPaused: begin
            if (sp) begin
               m_mode = MIdle;
               m_t    = 0;
            end else if (st && dc) m_mode = MCooking;
         end
         default: begin
            if (kv || st || sp || !dc) m_mode = MIdle;
         end
      endcase
   endtask

   task automatic cycle(input string tag, input logic tk, input logic kv, input int kc,
                        input logic st, input logic sp);
      bus.tick_1hz    = tk;
      bus.key_valid   = kv;
      bus.key_code    = 4'(kc);
      bus.start       = st;
      bus.stop        = sp;
      bus.door_closed = door;
      model_step(tk, kv, kc, st, sp, door);
      @(posedge clk);
      #1;
      bus.tick_1hz  = 1'b0;
      bus.key_valid = 1'b0;
      bus.start     = 1'b0;
      bus.stop      = 1'b0;
      check_outputs(tag);
   endtask

   task automatic key(input int k);
      cycle("key", 1'b0, 1'b1, k, 1'b0, 1'b0);
   endtask

   task automatic press_start();
      cycle("start", 1'b0, 1'b0, 0, 1'b1, 1'b0);
   endtask

   task automatic press_stop();
      cycle("stop", 1'b0, 1'b0, 0, 1'b0, 1'b1);
   endtask

   task automatic tick();
      cycle("tick", 1'b1, 1'b0, 0, 1'b0, 1'b0);
   endtask

   initial begin
      int budget;
      rst_n           = 1'b0;
      door            = 1'b1;
      bus.tick_1hz    = 1'b0;
      bus.key_valid   = 1'b0;
      bus.key_code    = 4'd0;
      bus.start       = 1'b0;
      bus.stop        = 1'b0;
      bus.door_closed = 1'b1;
      m_mode          = MIdle;
      m_t             = 0;
      #12;
      check_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Entry 1, 3, 0 -> 0:01, 0:13, 1:30
      key(1); key(3); key(0);

      // Invalid entry and cancel in IDLE
      press_stop();
      key(7); key(2); key(12);
      press_stop();
      press_start();

      // Countdown with borrow through to DONE
      key(1); key(0); key(0);
      press_start();
      tick(); tick(); tick();
      budget = 100;
      while (m_mode == MCooking && budget > 0) begin
         tick();
         budget--;
      end
      check("countdown_reaches_done", m_mode, MDone);
      key(5);

      // Door opens together with a tick at 0:45
      key(4); key(5);
      press_start();
      door = 1'b0;
      tick();
      press_start();
      door = 1'b1;
      cycle("door_close", 1'b0, 1'b0, 0, 1'b0, 1'b0);
      press_start();
      tick();
      press_stop();
      press_stop();

      // Pause and cancel at 2:10
      key(2); key(1); key(0);
      press_start();
      press_stop();
      press_start();
      press_stop();
      press_stop();

      // start and stop together in IDLE at 0:30
      key(3); key(0);
      cycle("start_stop", 1'b0, 1'b0, 0, 1'b1, 1'b1);

      // Asynchronous reset mid-cook at 0:20
      key(2); key(0);
      press_start();
      tick();
      #2;
      rst_n  = 1'b0;
      m_mode = MIdle;
      m_t    = 0;
      #1;
      check_outputs("async_reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 31) == 0) door = ~door;
         cycle("random",
               1'($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 3) == 0),
               int'($urandom_range(0, 15)),
               1'($urandom_range(0, 7) == 0),
               1'($urandom_range(0, 15) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
